// File: rtl/my_loop_pkg.sv
// rtl/my_loop_pkg.sv - shared constants, state encoding and saturation helper for the loop integrator
// Contents:
//   DAC_BIT_DFLT / MOD_BIT_DFLT : default DAC word and modulation amplitude widths
//   state_t                     : FSM encoding ST_IDLE(0) .. ST_DONE(4)
//   sat33to32                   : clamp a 33-bit signed sum into 32-bit signed range
package my_loop_pkg;

  localparam int DAC_BIT_DFLT = 16;
  localparam int MOD_BIT_DFLT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCALE = 3'd1,
    ST_STEP  = 3'd2,
    ST_RAMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Overflow exists exactly when the two top bits of the 33-bit sum disagree.
  function automatic logic signed [31:0] sat33to32(input logic signed [32:0] v);
    if (v[32] != v[31]) begin
      return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/my_loop_integrator_v1_if.sv
// rtl/my_loop_integrator_v1_if.sv - signal bundle between error demodulator, loop integrator and DAC driver
// Parameters: DAC_BIT (o_dac width), MOD_BIT (i_mod_amp width)
// Inputs to the integrator : i_err_vld, i_err, i_status, i_loop_en, i_const_step,
//                            i_gain1_sel, i_gain2_sel, i_mod_amp
// Outputs of the integrator: o_step, o_ramp, o_dac, o_vld, o_overrun, o_cstate
// Modports: master drives the inputs and observes outputs; slave is the integrator.
interface my_loop_integrator_v1_if
  import my_loop_pkg::*;
#(
  parameter int DAC_BIT = DAC_BIT_DFLT,
  parameter int MOD_BIT = MOD_BIT_DFLT
);

  logic                      i_err_vld;
  logic signed [31:0]        i_err;
  logic                      i_status;
  logic                      i_loop_en;
  logic signed [31:0]        i_const_step;
  logic        [4:0]         i_gain1_sel;
  logic        [4:0]         i_gain2_sel;
  logic        [MOD_BIT-1:0] i_mod_amp;

  logic signed [31:0]        o_step;
  logic        [31:0]        o_ramp;
  logic        [DAC_BIT-1:0] o_dac;
  logic                      o_vld;
  logic                      o_overrun;
  logic        [2:0]         o_cstate;

  modport master (
    output i_err_vld, i_err, i_status, i_loop_en, i_const_step,
           i_gain1_sel, i_gain2_sel, i_mod_amp,
    input  o_step, o_ramp, o_dac, o_vld, o_overrun, o_cstate
  );

  modport slave (
    input  i_err_vld, i_err, i_status, i_loop_en, i_const_step,
           i_gain1_sel, i_gain2_sel, i_mod_amp,
    output o_step, o_ramp, o_dac, o_vld, o_overrun, o_cstate
  );

endinterface

// File: rtl/my_mod_adder.sv
// rtl/my_mod_adder.sv - registered DAC word: ramp MSBs plus or minus the bias modulation amplitude
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   ramp_msb : top DAC_BIT bits of the phase ramp
//   status   : 1 = add amplitude, 0 = subtract amplitude
//   mod_amp  : bias amplitude in DAC LSBs
//   dac      : registered phase word, wraps modulo 2^DAC_BIT
module my_mod_adder #(
  parameter int DAC_BIT = 16,
  parameter int MOD_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DAC_BIT-1:0] ramp_msb,
  input  logic               status,
  input  logic [MOD_BIT-1:0] mod_amp,
  output logic [DAC_BIT-1:0] dac
);

  logic [DAC_BIT-1:0] amp_ext;

  // Bring the amplitude to DAC width; any bits above the DAC word vanish in the modulo anyway.
  if (MOD_BIT >= DAC_BIT) begin : g_amp_trunc
    assign amp_ext = mod_amp[DAC_BIT-1:0];
  end else begin : g_amp_zext
    assign amp_ext = {{(DAC_BIT-MOD_BIT){1'b0}}, mod_amp};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac <= '0;
    end else begin
      dac <= status ? (ramp_msb + amp_ext) : (ramp_msb - amp_ext);
    end
  end

endmodule

// File: rtl/my_loop_integrator_v1.sv
// rtl/my_loop_integrator_v1.sv - closed-loop error integrator: error -> step accumulator -> phase ramp -> DAC word
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : my_loop_integrator_v1_if.slave (error sample handshake, loop controls, step/ramp/dac outputs)
// Build option: define STEP_SAT_EN to saturate the step accumulator instead of letting it wrap.
// Sequence per accepted sample: IDLE -> SCALE -> STEP -> RAMP -> DONE (o_vld) -> IDLE.
module my_loop_integrator_v1
  import my_loop_pkg::*;
#(
  parameter int DAC_BIT = DAC_BIT_DFLT,
  parameter int MOD_BIT = MOD_BIT_DFLT
) (
  input logic                     i_clk,
  input logic                     i_rst,
  my_loop_integrator_v1_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;

  logic               cap_en;
  logic               drop;
  logic               vld;

  logic signed [31:0] err_cap;
  logic signed [31:0] err_s;
  logic signed [31:0] step;
  logic        [31:0] ramp;
  logic               overrun;

  logic signed [31:0] step_sum;
  logic signed [31:0] step_shr;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.i_err_vld) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_STEP;
      ST_STEP:  state_nxt = ST_RAMP;
      ST_RAMP:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cap_en = 1'b0;
    drop   = 1'b0;
    vld    = 1'b0;
    case (state)
      ST_IDLE: cap_en = bus.i_err_vld;
      ST_DONE: begin
        vld  = 1'b1;
        drop = bus.i_err_vld;
      end
      default: drop = bus.i_err_vld;
    endcase
  end

  // Step update. The 33-bit sum either clamps or is cut back to 32 bits (two's-complement wrap).
`ifdef STEP_SAT_EN
  logic signed [32:0] sum33;
  assign sum33    = {step[31], step} + {err_s[31], err_s};
  assign step_sum = sat33to32(sum33);
`else
  assign step_sum = step + err_s;
`endif

  assign step_shr = step >>> bus.i_gain2_sel;

  // Datapath: each register only moves in the state that owns it, so gains and
  // the open-loop step are sampled exactly when they are consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cap <= '0;
      err_s   <= '0;
      step    <= '0;
      ramp    <= '0;
      overrun <= 1'b0;
    end else begin
      if (cap_en) err_cap <= bus.i_err;
      if (drop)   overrun <= 1'b1;
      case (state)
        ST_SCALE: err_s <= err_cap >>> bus.i_gain1_sel;
        // Loading i_const_step while open makes re-closing the loop bumpless.
        ST_STEP:  step  <= bus.i_loop_en ? step_sum : bus.i_const_step;
        // Ramp wraps modulo 2^32 on purpose: it is a phase.
        ST_RAMP:  ramp  <= ramp + step_shr;
        default:  ;
      endcase
    end
  end

  my_mod_adder #(
    .DAC_BIT (DAC_BIT),
    .MOD_BIT (MOD_BIT)
  ) u_mod_adder (
    .clk      (i_clk),
    .rst      (i_rst),
    .ramp_msb (ramp[31 -: DAC_BIT]),
    .status   (bus.i_status),
    .mod_amp  (bus.i_mod_amp),
    .dac      (bus.o_dac)
  );

  assign bus.o_step    = step;
  assign bus.o_ramp    = ramp;
  assign bus.o_vld     = vld;
  assign bus.o_overrun = overrun;
  assign bus.o_cstate  = state;

endmodule

// File: tb/tb_my_loop_integrator_v1.sv
// tb/tb_my_loop_integrator_v1.sv - scoreboard bench for the loop integrator
module tb_my_loop_integrator_v1;
  import my_loop_pkg::*;

  typedef struct {
    logic [31:0] step;
    logic [31:0] ramp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  my_loop_integrator_v1_if bus ();

  my_loop_integrator_v1 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   vld_count = 0;
  int   mdl_step  = 0;
  int   mdl_ramp  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every o_vld pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_vld === 1'b1) begin
      vld_count++;
      if (sb_q.size() == 0) begin
        check("vld_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_step", bus.o_step, mon_e.step);
        check("sb_ramp", bus.o_ramp, mon_e.ramp);
      end
    end
  end

  task automatic model_push(input int err);
    exp_t   e;
    longint s;
    if (bus.i_loop_en) begin
      s = longint'(mdl_step) + longint'(err >>> bus.i_gain1_sel);
`ifdef STEP_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      mdl_step = int'(s);
    end else begin
      mdl_step = bus.i_const_step;
    end
    mdl_ramp = mdl_ramp + (mdl_step >>> bus.i_gain2_sel);
    e.step = mdl_step;
    e.ramp = mdl_ramp;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] dac_model();
    logic [31:0] r;
    logic [15:0] hi;
    r  = mdl_ramp;
    hi = r[31:16];
    return bus.i_status ? hi + bus.i_mod_amp : hi - bus.i_mod_amp;
  endfunction

  // One accepted sample with latency checks at N+2, N+3, N+4 and N+5.
  task automatic send(input int err);
    int prev_step;
    prev_step = mdl_step;
    model_push(err);
    @(negedge clk);
    bus.i_err_vld = 1'b1;
    bus.i_err     = err;
    @(negedge clk);
    bus.i_err_vld = 1'b0;
    @(negedge clk);
    check("step_not_yet", bus.o_step, prev_step);
    @(negedge clk);
    check("step_n3", bus.o_step, mdl_step);
    check("vld_low_n3", {31'd0, bus.o_vld}, 32'd0);
    @(negedge clk);
    check("vld_n4", {31'd0, bus.o_vld}, 32'd1);
    @(negedge clk);
    check("dac_n5", {16'd0, bus.o_dac}, {16'd0, dac_model()});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_err_vld = 1'b0;
    #1;
    check("rst_step", bus.o_step, 32'd0);
    check("rst_ramp", bus.o_ramp, 32'd0);
    check("rst_dac", {16'd0, bus.o_dac}, 32'd0);
    check("rst_vld", {31'd0, bus.o_vld}, 32'd0);
    check("rst_overrun", {31'd0, bus.o_overrun}, 32'd0);
    check("rst_state", {29'd0, bus.o_cstate}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_step = 0;
    mdl_ramp = 0;
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    bus.i_err_vld    = 1'b0;
    bus.i_err        = 0;
    bus.i_status     = 1'b1;
    bus.i_loop_en    = 1'b1;
    bus.i_const_step = 0;
    bus.i_gain1_sel  = 5'd0;
    bus.i_gain2_sel  = 5'd0;
    bus.i_mod_amp    = '0;
    repeat (2) @(negedge clk);

    // Single sample, unity gains.
    do_reset();
    send(100);
    check("single_step", bus.o_step, 32'd100);
    check("single_ramp", bus.o_ramp, 32'd100);

    // Ten samples with error gain 1/4.
    do_reset();
    bus.i_gain1_sel = 5'd2;
    for (int i = 0; i < 10; i++) send(64);
    check("ten_step", bus.o_step, 32'd160);
    check("ten_ramp", bus.o_ramp, 32'd880);

    // Negative error with nonzero ramp gain.
    do_reset();
    bus.i_gain1_sel = 5'd3;
    bus.i_gain2_sel = 5'd4;
    for (int i = 0; i < 4; i++) send(-1000 - 37 * i);

    // Open loop: ramp wraps after four steps of a quarter turn.
    do_reset();
    bus.i_loop_en    = 1'b0;
    bus.i_const_step = 32'sh4000_0000;
    bus.i_gain2_sel  = 5'd0;
    send(5);
    check("open_r1", bus.o_ramp, 32'h4000_0000);
    send(5);
    check("open_r2", bus.o_ramp, 32'h8000_0000);
    send(5);
    check("open_r3", bus.o_ramp, 32'hC000_0000);
    send(5);
    check("open_wrap", bus.o_ramp, 32'h0000_0000);

    // Bumpless re-close and step overflow.
    do_reset();
    bus.i_loop_en    = 1'b0;
    bus.i_const_step = 32'sh7FFF_FFF0;
    bus.i_gain1_sel  = 5'd0;
    send(0);
    bus.i_loop_en = 1'b1;
    send(32'h100);
`ifdef STEP_SAT_EN
    check("sat_step", bus.o_step, 32'h7FFF_FFFF);
`else
    check("wrap_step", bus.o_step, 32'h8000_00F0);
`endif

    // Bias modulation on a zero ramp.
    do_reset();
    bus.i_mod_amp = 16'h4000;
    bus.i_status  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dac_toggle", {16'd0, bus.o_dac}, bus.i_status ? 32'h4000 : 32'hC000);
      bus.i_status = ~bus.i_status;
    end
    bus.i_mod_amp = '0;
    bus.i_status  = 1'b1;

    // Overrun: second pulse two clocks after the first is dropped.
    do_reset();
    bus.i_gain1_sel = 5'd0;
    bus.i_gain2_sel = 5'd0;
    vc0 = vld_count;
    model_push(50);
    @(negedge clk); bus.i_err_vld = 1'b1; bus.i_err = 50;
    @(negedge clk); bus.i_err_vld = 1'b0;
    @(negedge clk); bus.i_err_vld = 1'b1; bus.i_err = 999;
    @(negedge clk); bus.i_err_vld = 1'b0;
    repeat (4) @(negedge clk);
    check("overrun_set", {31'd0, bus.o_overrun}, 32'd1);
    check("overrun_one_vld", vld_count - vc0, 32'd1);
    check("overrun_step", bus.o_step, 32'd50);

    // Reset during RAMP aborts the sample with no o_vld.
    vc0 = vld_count;
    @(negedge clk); bus.i_err_vld = 1'b1; bus.i_err = 7;
    @(negedge clk); bus.i_err_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_ramp", {29'd0, bus.o_cstate}, {29'd0, ST_RAMP});
    rst = 1'b1;
    #1;
    check("abort_step", bus.o_step, 32'd0);
    check("abort_ramp", bus.o_ramp, 32'd0);
    check("abort_dac", {16'd0, bus.o_dac}, 32'd0);
    check("abort_overrun", {31'd0, bus.o_overrun}, 32'd0);
    check("abort_state", {29'd0, bus.o_cstate}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_step = 0;
    mdl_ramp = 0;
    repeat (6) @(negedge clk);
    check("abort_no_vld", vld_count - vc0, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
